iir_sos_sequencer: RTL and testbench

//  Time-multiplexed cascade of NSEC second-order IIR sections on one shared transposed-DF2 biquad datapath.

---
 rtl/iir_sos_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_iir_sos_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sos_sequencer.sv
// Time-multiplexed cascade of NSEC transposed-DF2 biquads on one shared datapath.
// Optional saturating arithmetic: define IIR_SEQ_SAT_EN (default build wraps modulo 2^w).
module iir_sos_sequencer #(
  parameter int w    = 32,
  parameter int FW   = 16,
  parameter int NSEC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [w-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [w-1:0] out,
  input  logic         cfg_we,
  input  logic [7:0]   cfg_addr,
  input  logic [w-1:0] cfg_data,
  input  logic         clr_state,
  output logic         cfg_err,
  output logic         sat_flag
);

  localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;
`ifdef IIR_SEQ_SAT_EN
  localparam int PW = w + 2;
`else
  localparam int PW = w;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;
  logic [SW-1:0]       sec;
  logic signed [w-1:0] x;

  logic signed [w-1:0] cn0 [NSEC];
  logic signed [w-1:0] cn1 [NSEC];
  logic signed [w-1:0] cn2 [NSEC];
  logic signed [w-1:0] cd1 [NSEC];
  logic signed [w-1:0] cd2 [NSEC];
  logic signed [w-1:0] s0  [NSEC];
  logic signed [w-1:0] s1  [NSEC];

  logic idle, accept, cfg_ok, clr_ok, last, step;

  // Full 2w-bit product, arithmetic shift, keep PW bits (w+2 when saturating).
  function automatic logic signed [PW-1:0] mulq(input logic signed [w-1:0] c,
                                                input logic signed [w-1:0] v);
    logic signed [2*w-1:0] pr;
    pr = c * v;
    pr = pr >>> FW;
    return pr[PW-1:0];
  endfunction

`ifdef IIR_SEQ_SAT_EN
  function automatic logic ovf(input logic [PW-1:0] v);
    return !((&v[PW-1:w-1]) | ~(|v[PW-1:w-1]));
  endfunction

  function automatic logic signed [w-1:0] clampw(input logic [PW-1:0] v);
    if (!ovf(v))       return v[w-1:0];
    else if (v[PW-1])  return {1'b1, {(w-1){1'b0}}};
    else               return {1'b0, {(w-1){1'b1}}};
  endfunction
`endif

  assign idle     = (state == IDLE);
  assign in_ready = idle & en & ~rst;
  assign accept   = in_valid & in_ready;
  assign cfg_ok   = cfg_we & idle & (cfg_addr < 8'(5 * NSEC));
  assign clr_ok   = clr_state & idle;
  assign last     = (sec == SW'(NSEC - 1));
  assign step     = (state == RUN) & en;

  // Shared section datapath
  logic signed [PW-1:0] y_w, s0_w, s1_w;
  logic signed [w-1:0]  y, s0n, s1n;
  logic                 sat_hit;

  always_comb begin
    y_w  = mulq(cn0[sec], x) + PW'(s0[sec]);
`ifdef IIR_SEQ_SAT_EN
    y    = clampw(y_w);
`else
    y    = y_w;
`endif
    s0_w = mulq(cn1[sec], x) - mulq(cd1[sec], y) + PW'(s1[sec]);
    s1_w = mulq(cn2[sec], x) - mulq(cd2[sec], y);
`ifdef IIR_SEQ_SAT_EN
    s0n     = clampw(s0_w);
    s1n     = clampw(s1_w);
    sat_hit = ovf(y_w) | ovf(s0_w) | ovf(s1_w);
`else
    s0n     = s0_w;
    s1n     = s1_w;
    sat_hit = 1'b0;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (en && last) state_nx = DONE;
      // out_valid may already have been dropped by out_ready while en was low
      DONE:    if (en && (out_ready || !out_valid)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec       <= '0;
      x         <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= (cfg_we & ~cfg_ok) | (clr_state & ~idle);
      if (accept) begin
        x   <= in;
        sec <= '0;
      end else if (step) begin
        x <= y;
        if (last) begin
          out       <= y;
          out_valid <= 1'b1;
        end else begin
          sec <= sec + 1'b1;
        end
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end

`ifdef IIR_SEQ_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sat_flag <= 1'b0;
    else if (clr_ok)         sat_flag <= 1'b0;
    else if (step & sat_hit) sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSEC; i++) begin
        cn0[i] <= w'(1) <<< FW;
        cn1[i] <= '0;
        cn2[i] <= '0;
        cd1[i] <= '0;
        cd2[i] <= '0;
      end
    end else if (cfg_ok) begin
      for (int unsigned i = 0; i < NSEC; i++) begin
        if (cfg_addr == 8'(5 * i))     cn0[i] <= cfg_data;
        if (cfg_addr == 8'(5 * i + 1)) cn1[i] <= cfg_data;
        if (cfg_addr == 8'(5 * i + 2)) cn2[i] <= cfg_data;
        if (cfg_addr == 8'(5 * i + 3)) cd1[i] <= cfg_data;
        if (cfg_addr == 8'(5 * i + 4)) cd2[i] <= cfg_data;
      end
    end
  end

  // clr_state and RUN write-back are mutually exclusive (clear is IDLE-only)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSEC; i++) begin
        s0[i] <= '0;
        s1[i] <= '0;
      end
    end else if (clr_ok) begin
      for (int unsigned i = 0; i < NSEC; i++) begin
        s0[i] <= '0;
        s1[i] <= '0;
      end
    end else if (step) begin
      s0[sec] <= s0n;
      s1[sec] <= s1n;
    end
  end

endmodule

// File: tb/tb_iir_sos_sequencer.sv
// Scoreboard bench for iir_sos_sequencer (w=32, FW=16, NSEC=2); directed vectors.
module tb_iir_sos_sequencer;
  localparam int W  = 32;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst, en, in_valid, in_ready, out_valid, out_ready;
  logic cfg_we, clr_state, cfg_err, sat_flag;
  logic [W-1:0] in_data, out_data, cfg_data;
  logic [7:0]   cfg_addr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  iir_sos_sequencer #(.w(W), .FW(16), .NSEC(NS)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .clr_state(clr_state), .cfg_err(cfg_err), .sat_flag(sat_flag)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pop one expectation per completed output handshake
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h, expected none at %0t", out_data, $time);
      end else begin
        chk("out", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic wcfg(input logic [7:0] a, input logic [W-1:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_we   = 1'b1;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_state = 1'b1;
    @(posedge clk); #1;
    clr_state = 1'b0;
  endtask

  // Returns 1 ns after the accepting edge
  task automatic send(input logic [W-1:0] x, input bit push, input logic [W-1:0] e, input bit clr);
    bit done = 1'b0;
    if (push) exp_q.push_back(e);
    in_data  = x;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        clr_state = clr;
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    in_valid  = 1'b0;
    clr_state = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no in_ready, expected accept for %h", x);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (exp_q.size() == 0 && out_valid == 1'b0) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b0; clr_state = 1'b0; cfg_addr = '0; cfg_data = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out_data, 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 1: passthrough, latency NSEC
    send(32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0);
    @(posedge clk); #1;
    chk("lat_T1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_T2_valid", 32'(out_valid), 32'd1);
    chk("t1_cfg_err", 32'(cfg_err), 32'd0);
    drain();

    // 2: n0 of section 0 = 0.5
    wcfg(8'd0, 32'h0000_8000);
    chk("good_wr_cfg_err", 32'(cfg_err), 32'd0);
    send(32'h0001_0000, 1'b1, 32'h0000_8000, 1'b0);
    drain();
    wcfg(8'd0, 32'h0001_0000);

    // Out-of-range address is rejected
    wcfg(8'd10, 32'h0000_1234);
    chk("badaddr_cfg_err", 32'(cfg_err), 32'd1);
    @(posedge clk); #1;
    chk("badaddr_pulse_end", 32'(cfg_err), 32'd0);

    // 3: FIR 1,1,1 in section 0
    clr_pulse();
    chk("clr_idle_cfg_err", 32'(cfg_err), 32'd0);
    wcfg(8'd1, 32'h0001_0000);
    wcfg(8'd2, 32'h0001_0000);
    send(32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0);
    send(32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0);
    send(32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0);
    send(32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
    drain();
    wcfg(8'd1, 32'h0000_0000);
    wcfg(8'd2, 32'h0000_0000);

    // 4: one-pole, d1=-0.5, then clr_state on the accepting edge
    clr_pulse();
    wcfg(8'd3, 32'hFFFF_8000);
    send(32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0);
    send(32'h0000_0000, 1'b1, 32'h0000_8000, 1'b0);
    send(32'h0000_0000, 1'b1, 32'h0000_4000, 1'b0);
    send(32'h0000_0000, 1'b1, 32'h0000_2000, 1'b0);
    send(32'h0001_0000, 1'b1, 32'h0001_0000, 1'b1);
    drain();
    wcfg(8'd3, 32'h0000_0000);
    clr_pulse();

    // en=0 during RUN freezes the pipeline
    send(32'h0003_0000, 1'b1, 32'h0003_0000, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("en0_hold_valid", 32'(out_valid), 32'd0);
    end
    chk("en0_in_ready", 32'(in_ready), 32'd0);
    en = 1'b1;
    drain();

    // 5a: backpressure holds out/out_valid
    out_ready = 1'b0;
    send(32'h0002_0000, 1'b1, 32'h0002_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_out", out_data, 32'h0002_0000);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // 5b: cfg write during RUN is dropped
    send(32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0);
    wcfg(8'd0, 32'h0000_8000);
    chk("run_wr_cfg_err", 32'(cfg_err), 32'd1);
    @(posedge clk); #1;
    chk("run_wr_pulse_end", 32'(cfg_err), 32'd0);
    drain();
    send(32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0);
    drain();

    // 5c: reset mid-RUN aborts the sample and restores passthrough
    wcfg(8'd0, 32'h0000_8000);
    send(32'h0001_0000, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_out", 32'(out_valid), 32'd0);
    send(32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0);
    drain();

    // 6: overflow of n0=2.0 on 0x7000_0000
    wcfg(8'd0, 32'h0002_0000);
`ifdef IIR_SEQ_SAT_EN
    send(32'h7000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0);
    drain();
    chk("sat_flag_set", 32'(sat_flag), 32'd1);
    clr_pulse();
    chk("sat_flag_clr", 32'(sat_flag), 32'd0);
`else
    send(32'h7000_0000, 1'b1, 32'hE000_0000, 1'b0);
    drain();
    chk("sat_flag_off", 32'(sat_flag), 32'd0);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
